// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: multi-cycle word/byte loads, word stores, misalignment flag.
// Optional byte stores (port Sb) are enabled by defining DMEM_BYTE_STORE_EN.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Lb,
  input  logic        LoadExtended,
  input  logic [31:0] MemoryAddress,
  input  logic [31:0] MemoryWriteData,
`ifdef DMEM_BYTE_STORE_EN
  input  logic        Sb,
`endif
  output logic [31:0] MemoryReadData,
  output logic        Stall,
  output logic        Ready,
  output logic        Misaligned
);

  localparam logic [3:0] CntInit = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam bit         Lat1    = (LATENCY == 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        lane_q;
  logic              store_q, byte_ld_q, sext_q, sb_q, mis_cap_q, mis_out_q;
  logic [31:0]       wdata_q, rdata_q;

  logic [31:0]       mem [DEPTH];

  logic              req, in_idle, in_sb, in_byte_ld, in_mis, commit;
  logic [ADDR_W-1:0] acc_idx;
  logic [1:0]        acc_lane;
  logic              acc_store, acc_byte, acc_sext, acc_sb, acc_mis;
  logic [31:0]       acc_wdata, mem_word, load_val;
  logic [7:0]        sel_byte;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^MemoryAddress[31:ADDR_W+2];

  assign req        = MemRead | MemWrite;
  assign in_idle    = (state_q == StIdle);
`ifdef DMEM_BYTE_STORE_EN
  assign in_sb      = MemWrite & Sb;
`else
  assign in_sb      = 1'b0;
`endif
  // Read+write together is a store, so the byte-load qualifier is dropped.
  assign in_byte_ld = MemRead & Lb & ~MemWrite;
  assign in_mis     = (MemoryAddress[1:0] != 2'b00) & ~in_sb & ~in_byte_ld;

  // With LATENCY=1 the access commits on the acceptance edge, so use live inputs in IDLE.
  assign acc_idx   = in_idle ? MemoryAddress[ADDR_W+1:2] : idx_q;
  assign acc_lane  = in_idle ? MemoryAddress[1:0]        : lane_q;
  assign acc_store = in_idle ? MemWrite                  : store_q;
  assign acc_byte  = in_idle ? in_byte_ld                : byte_ld_q;
  assign acc_sext  = in_idle ? LoadExtended              : sext_q;
  assign acc_sb    = in_idle ? in_sb                     : sb_q;
  assign acc_mis   = in_idle ? in_mis                    : mis_cap_q;
  assign acc_wdata = in_idle ? MemoryWriteData           : wdata_q;

  assign commit = ~Rst & ((in_idle & req & Lat1) | ((state_q == StWait) & (cnt_q == 4'd0)));

  assign mem_word = mem[acc_idx];
  assign sel_byte = mem_word[{acc_lane, 3'b000} +: 8];

  always_comb begin
    load_val = mem_word;
    if (acc_byte) begin
      load_val = acc_sext ? {{24{sel_byte[7]}}, sel_byte} : {24'h0, sel_byte};
    end
  end

  // Array has no reset; writes only on a committed, aligned store.
  always_ff @(posedge Clk) begin
    if (commit && acc_store && !acc_mis) begin
      if (acc_sb) begin
        mem[acc_idx][{acc_lane, 3'b000} +: 8] <= acc_wdata[7:0];
      end else begin
        mem[acc_idx] <= acc_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = Lat1 ? StDone : StWait;
          cnt_d   = CntInit;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      lane_q    <= 2'b00;
      store_q   <= 1'b0;
      byte_ld_q <= 1'b0;
      sext_q    <= 1'b0;
      sb_q      <= 1'b0;
      mis_cap_q <= 1'b0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      mis_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (in_idle && req) begin
        idx_q     <= MemoryAddress[ADDR_W+1:2];
        lane_q    <= MemoryAddress[1:0];
        store_q   <= MemWrite;
        byte_ld_q <= in_byte_ld;
        sext_q    <= LoadExtended;
        sb_q      <= in_sb;
        mis_cap_q <= in_mis;
        wdata_q   <= MemoryWriteData;
      end
      if (commit) begin
        rdata_q   <= (acc_store || acc_mis) ? 32'h0 : load_val;
        mis_out_q <= acc_mis;
      end
    end
  end

  always_comb begin
    Stall = 1'b0;
    unique case (state_q)
      StIdle:  Stall = req;
      StWait:  Stall = 1'b1;
      StDone:  Stall = 1'b0;
      default: Stall = 1'b0;
    endcase
    Stall = Stall & ~Rst;
  end

  assign Ready          = (state_q == StDone) & ~Rst;
  assign Misaligned     = Ready & mis_out_q;
  assign MemoryReadData = rdata_q;

endmodule
